// File: rtl/sd_spi_pkg.sv
// Shared types and well-known frames for the SPI-mode SD command engine.
package sd_spi_pkg;

  typedef enum logic [2:0] {IDLE, SEND, POLL, RECV, DONE} sdState_t;

  localparam logic [47:0] SD_CMD0_FRAME = 48'h400000000095;
  localparam logic [47:0] SD_CMD8_FRAME = 48'h48000001AA87;
  localparam logic [7:0]  SD_R1_IDLE    = 8'h01;
  localparam logic [7:0]  SD_IDLE_BYTE  = 8'hFF;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1) over the 40 header/argument bits of an SD command.
module sd_crc7 (
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  logic fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: sends one frame, polls for the response start byte, captures the response.
// Build macro SD_CRC7_EN replaces cmd[7:0] on the wire with {CRC7, 1'b1}.
//
// state | meaning
// IDLE  | CS high, waiting for a command
// SEND  | shifting the command frame out on MOSI
// POLL  | 8-bit slots on MISO until a byte with bit7 == 0
// RECV  | capturing the remaining response bytes
// DONE  | 8 trailing SCK cycles, then CS release and resp_valid
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int CMD_BITS       = 48,
  parameter int MAX_RESP_BYTES = 5,
  parameter int NCR_MAX        = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CMD_BITS-1:0]         cmd,
  input  logic [2:0]                  resp_len,
  output logic                        resp_valid,
  output logic [8*MAX_RESP_BYTES-1:0] resp_data,
  output logic                        resp_timeout,
  output logic                        busy,
  output logic                        sd_sck,
  output logic                        sd_cs_n,
  output logic                        sd_mosi,
  input  logic                        sd_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = ($clog2(CMD_BITS + 1) > 3) ? $clog2(CMD_BITS + 1) : 3;
  localparam int SW = ($clog2(NCR_MAX + 1) > 1) ? $clog2(NCR_MAX + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] SEND_LAST = BW'(CMD_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCR_MAX - 1);
  localparam logic [2:0]    MAX_LEN   = 3'(MAX_RESP_BYTES);

  sdState_t state, stateNext;
  logic [DW-1:0] divCnt;
  logic [BW-1:0] bitCnt;
  logic [SW-1:0] slotCnt;
  logic [CMD_BITS-1:0] shiftOut, txFrame;
  logic [7:0] rxShift;
  logic [2:0] respLen, byteCnt, lenClamped;
  logic [MAX_RESP_BYTES-1:0][7:0] respBytes;
  logic sckReg, csN, timedOut, respValidReg, respTimeoutReg;
  logic accept, tick, sckRise, sckFall, byteEnd, startSeen, pollTimeout, finish;

`ifdef SD_CRC7_EN
  logic [6:0] crc;
  if (CMD_BITS != 48) begin : gBadFrame
    $error("sd_spi_cmd_engine: SD_CRC7_EN needs CMD_BITS == 48");
  end
  sd_crc7 uCrc (.data(cmd[47:8]), .crc(crc));
  assign txFrame = {cmd[47:8], crc, 1'b1};
`else
  assign txFrame = cmd;
`endif

  assign accept    = cmd_valid && (state == IDLE);
  assign tick      = (state != IDLE) && (divCnt == DIV_LAST);
  assign sckRise   = tick && !sckReg;
  assign sckFall   = tick && sckReg;
  // Byte boundaries fall on every 8th SCK falling edge since the state was entered.
  assign byteEnd   = sckFall && (bitCnt[2:0] == 3'd7);
  assign startSeen = !rxShift[7];

  always_comb begin
    lenClamped = resp_len;
    if (resp_len == 3'd0)        lenClamped = 3'd1;
    else if (resp_len > MAX_LEN) lenClamped = MAX_LEN;
  end

  always_comb begin
    stateNext   = state;
    pollTimeout = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = SEND;
      SEND: if (sckFall && bitCnt == SEND_LAST) stateNext = POLL;
      POLL: if (byteEnd) begin
        if (startSeen) stateNext = (respLen == 3'd1) ? DONE : RECV;
        else if (slotCnt == SLOT_LAST) begin
          stateNext   = DONE;
          pollTimeout = 1'b1;
        end
      end
      RECV: if (byteEnd && byteCnt == respLen - 3'd1) stateNext = DONE;
      DONE: if (byteEnd) begin
        stateNext = IDLE;
        finish    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divCnt         <= '0;
      bitCnt         <= '0;
      slotCnt        <= '0;
      shiftOut       <= '1;
      rxShift        <= '1;
      respLen        <= 3'd1;
      byteCnt        <= '0;
      respBytes      <= '1;
      sckReg         <= 1'b0;
      csN            <= 1'b1;
      timedOut       <= 1'b0;
      respValidReg   <= 1'b0;
      respTimeoutReg <= 1'b0;
    end else begin
      respValidReg   <= 1'b0;
      respTimeoutReg <= 1'b0;
      if (state == IDLE || tick) divCnt <= '0;
      else                       divCnt <= divCnt + 1'b1;
      if (tick) sckReg <= !sckReg;
      if (stateNext != state) bitCnt <= '0;
      else if (sckFall)       bitCnt <= bitCnt + 1'b1;
      if (sckRise) rxShift <= {rxShift[6:0], sd_miso};
      if (accept) begin
        shiftOut  <= txFrame;
        csN       <= 1'b0;
        respLen   <= lenClamped;
        respBytes <= '1;
        byteCnt   <= '0;
        slotCnt   <= '0;
        timedOut  <= 1'b0;
      end
      // Ones shift in behind the frame, so MOSI idles high once the last bit is out.
      if (state == SEND && sckFall) shiftOut <= {shiftOut[CMD_BITS-2:0], 1'b1};
      if (state == POLL && byteEnd) begin
        slotCnt <= slotCnt + 1'b1;
        if (startSeen) begin
          respBytes[0] <= rxShift;
          byteCnt      <= 3'd1;
        end
      end
      if (pollTimeout) timedOut <= 1'b1;
      if (state == RECV && byteEnd) begin
        respBytes[byteCnt] <= rxShift;
        byteCnt            <= byteCnt + 3'd1;
      end
      if (finish) begin
        csN            <= 1'b1;
        respValidReg   <= 1'b1;
        respTimeoutReg <= timedOut;
      end
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign resp_valid   = respValidReg;
  assign resp_timeout = respTimeoutReg;
  assign resp_data    = respBytes;
  assign sd_sck       = sckReg;
  assign sd_cs_n      = csN;
  assign sd_mosi      = shiftOut[CMD_BITS-1];

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: three instances (CLK_DIV 1/2/4) sharing one SD card model on a wired bus.
module tb_sd_spi_cmd_engine;

  localparam int NCR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [47:0] cmdIn;
  logic [2:0]  lenIn;
  logic        sdMiso;
  logic        cmdValidW [3];
  logic        cmdReadyW [3];
  logic        respValidW [3];
  logic        respTimeoutW [3];
  logic        busyW [3];
  logic        sckW [3];
  logic        csW [3];
  logic        mosiW [3];
  logic [39:0] respDataW [3];

  sd_spi_cmd_engine #(.CLK_DIV(1), .CMD_BITS(48), .MAX_RESP_BYTES(5), .NCR_MAX(NCR)) u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmdValidW[0]), .cmd_ready(cmdReadyW[0]),
    .cmd(cmdIn), .resp_len(lenIn), .resp_valid(respValidW[0]), .resp_data(respDataW[0]),
    .resp_timeout(respTimeoutW[0]), .busy(busyW[0]), .sd_sck(sckW[0]), .sd_cs_n(csW[0]),
    .sd_mosi(mosiW[0]), .sd_miso(sdMiso));

  sd_spi_cmd_engine #(.CLK_DIV(2), .CMD_BITS(48), .MAX_RESP_BYTES(5), .NCR_MAX(NCR)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmdValidW[1]), .cmd_ready(cmdReadyW[1]),
    .cmd(cmdIn), .resp_len(lenIn), .resp_valid(respValidW[1]), .resp_data(respDataW[1]),
    .resp_timeout(respTimeoutW[1]), .busy(busyW[1]), .sd_sck(sckW[1]), .sd_cs_n(csW[1]),
    .sd_mosi(mosiW[1]), .sd_miso(sdMiso));

  sd_spi_cmd_engine #(.CLK_DIV(4), .CMD_BITS(48), .MAX_RESP_BYTES(5), .NCR_MAX(NCR)) u2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmdValidW[2]), .cmd_ready(cmdReadyW[2]),
    .cmd(cmdIn), .resp_len(lenIn), .resp_valid(respValidW[2]), .resp_data(respDataW[2]),
    .resp_timeout(respTimeoutW[2]), .busy(busyW[2]), .sd_sck(sckW[2]), .sd_cs_n(csW[2]),
    .sd_mosi(mosiW[2]), .sd_miso(sdMiso));

  // Only one instance is active at a time; idle ones hold SCK low, CS high, MOSI high.
  wire cardSck  = sckW[0] | sckW[1] | sckW[2];
  wire cardCs   = csW[0] & csW[1] & csW[2];
  wire cardMosi = mosiW[0] & mosiW[1] & mosiW[2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  cardQ [$];
  logic [47:0] capFrame;
  int capBits, frameCount, sckRises, rvCount, rvAll, mosiBad, minPer, maxPer;
  int lastRise, clkCnt, bitIdx, cur;
  logic lastRiseOk, prevSck, prevCs, prevMosi, lastTimeout;
  logic [39:0] lastData;
  logic [7:0]  curByte;

  function automatic int divOf(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [47:0] wireOf(input logic [47:0] c);
`ifdef SD_CRC7_EN
    logic [46:0] r;
    r = {c[47:8], 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] = r[i-:8] ^ 8'b1000_1001;
    return {c[47:8], r[6:0], 1'b1};
`else
    return c;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SD card model and bus monitor, evaluated on the falling clk edge.
  initial begin
    sdMiso = 1'b1; prevSck = 1'b0; prevCs = 1'b1; prevMosi = 1'b1;
    capBits = 0; capFrame = '0; frameCount = 0; sckRises = 0; rvCount = 0; rvAll = 0;
    mosiBad = 0; minPer = 1000; maxPer = 0; lastRise = 0; clkCnt = 0; bitIdx = 0;
    cur = 1; lastRiseOk = 1'b0; lastTimeout = 1'b0; lastData = '0; curByte = 8'hFF;
    forever begin
      @(negedge clk);
      clkCnt++;
      if (respValidW[0] | respValidW[1] | respValidW[2]) rvAll++;
      if (respValidW[cur]) begin
        rvCount++;
        lastData    = respDataW[cur];
        lastTimeout = respTimeoutW[cur];
      end
      if (cardCs) begin
        sdMiso     = 1'b1;
        lastRiseOk = 1'b0;
      end else begin
        if (prevCs) begin
          capBits = 0; capFrame = '0; bitIdx = 0;
        end
        if (cardSck && !prevSck) begin
          sckRises++;
          if (lastRiseOk) begin
            if (clkCnt - lastRise < minPer) minPer = clkCnt - lastRise;
            if (clkCnt - lastRise > maxPer) maxPer = clkCnt - lastRise;
          end
          lastRise = clkCnt; lastRiseOk = 1'b1;
          if (capBits < 48) begin
            capFrame = {capFrame[46:0], cardMosi};
            capBits++;
            if (capBits == 48) frameCount++;
          end
        end
        if (!cardSck && prevSck && capBits == 48) begin
          if (bitIdx == 0) curByte = (cardQ.size() > 0) ? cardQ.pop_front() : 8'hFF;
          sdMiso = curByte[7 - bitIdx];
          bitIdx = (bitIdx + 1) % 8;
        end
        if (!prevCs && cardSck && cardMosi !== prevMosi) mosiBad++;
        if (capBits == 48 && !cardSck && cardMosi !== 1'b1) mosiBad++;
      end
      prevSck = cardSck; prevCs = cardCs; prevMosi = cardMosi;
    end
  end

  task automatic runTxn(input int k, input logic [47:0] c, input logic [2:0] len,
                        input bit pulseBusy, input string name);
    logic [7:0]  refQ [$];
    logic [39:0] expData;
    logic        expTo;
    int effLen, start, nCyc, waitCnt;
    refQ   = cardQ;
    effLen = (len == 0) ? 1 : (len > 5) ? 5 : int'(len);
    start  = -1;
    for (int i = 0; i < NCR; i++)
      if (start < 0 && i < refQ.size() && !refQ[i][7]) start = i;
    expTo   = (start < 0);
    expData = '1;
    if (!expTo)
      for (int j = 0; j < effLen; j++)
        expData[8*j +: 8] = (start + j < refQ.size()) ? refQ[start + j] : 8'hFF;
    nCyc = expTo ? 48 + 8*NCR + 8 : 48 + 8*(start + effLen) + 8;

    cur = k; sckRises = 0; rvCount = 0; frameCount = 0; mosiBad = 0; minPer = 1000; maxPer = 0;
    @(posedge clk); #1;
    cmdIn = c; lenIn = len; cmdValidW[k] = 1'b1;
    @(posedge clk); #1;
    cmdValidW[k] = 1'b0;
    chk({name, ".busy"}, busyW[k], 1);
    chk({name, ".ready_low"}, cmdReadyW[k], 0);
    if (pulseBusy) begin
      repeat (40) @(posedge clk);
      #1;
      cmdIn = ~c; cmdValidW[k] = 1'b1;
      chk({name, ".ready_busy"}, cmdReadyW[k], 0);
      @(posedge clk); #1;
      cmdValidW[k] = 1'b0;
    end
    waitCnt = 0;
    while (rvCount == 0 && waitCnt < 20000) begin
      @(negedge clk);
      waitCnt++;
    end
    chk({name, ".resp_seen"}, (rvCount > 0), 1);
    repeat (8*divOf(k) + 20) @(negedge clk);
    chk({name, ".frame"}, capFrame, wireOf(c));
    chk({name, ".timeout"}, lastTimeout, expTo);
    chk({name, ".data"}, lastData, expData);
    chk({name, ".data_hold"}, respDataW[k], expData);
    chk({name, ".sck_cycles"}, sckRises, nCyc);
    chk({name, ".resp_pulses"}, rvCount, 1);
    chk({name, ".frames"}, frameCount, 1);
    chk({name, ".mosi_timing"}, mosiBad, 0);
    chk({name, ".sck_per_min"}, minPer, 2*divOf(k));
    chk({name, ".sck_per_max"}, maxPer, 2*divOf(k));
    chk({name, ".idle_pins"}, {csW[k], sckW[k], mosiW[k], cmdReadyW[k], busyW[k]}, 5'b10110);
  endtask

  initial begin
    int waitCnt, lead, k;
    logic [2:0] len;
    reset_n = 1'b0; cmdIn = '0; lenIn = 3'd1;
    for (int i = 0; i < 3; i++) cmdValidW[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", cmdReadyW[1], 1);
    chk("rst.busy", busyW[1], 0);
    chk("rst.resp_valid", respValidW[1], 0);
    chk("rst.resp_timeout", respTimeoutW[1], 0);
    chk("rst.resp_data", respDataW[1], 40'hFF_FFFF_FFFF);
    chk("rst.sck", sckW[1], 0);
    chk("rst.cs_n", csW[1], 1);
    chk("rst.mosi", mosiW[1], 1);
    reset_n = 1'b1;

    cardQ = '{8'hFF, 8'hFF, 8'h01};
    runTxn(1, 48'h400000000095, 3'd1, 1'b0, "cmd0");
    chk("cmd0.r1", lastData[7:0], 8'h01);

    cardQ = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    runTxn(1, 48'h48000001AA87, 3'd5, 1'b0, "cmd8");
    chk("cmd8.r7", lastData, 40'hAA_0100_0001);

    cardQ.delete();
    runTxn(1, 48'h400000000095, 3'd3, 1'b0, "all_ff");
    chk("all_ff.flag", lastTimeout, 1);

    cardQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h5A};
    runTxn(1, 48'h48000001AA87, 3'd2, 1'b0, "slot8");
    chk("slot8.flag", lastTimeout, 0);

    cardQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    runTxn(1, 48'h48000001AA87, 3'd1, 1'b0, "slot9");

    cardQ = '{8'hFF, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    runTxn(1, 48'h7A0000000001, 3'd7, 1'b0, "clamp7");
    cardQ = '{8'hFF, 8'h05, 8'h11, 8'h22};
    runTxn(1, 48'h7A0000000001, 3'd0, 1'b0, "clamp0");

    cardQ = '{8'hFF, 8'h01};
    runTxn(0, 48'h400000000095, 3'd1, 1'b1, "div1");
    cardQ = '{8'hFF, 8'h01};
    runTxn(2, 48'h400000000095, 3'd1, 1'b1, "div4");

    cardQ = '{8'h01};
    runTxn(1, 48'h4000000000FF, 3'd1, 1'b0, "crc");
`ifdef SD_CRC7_EN
    chk("crc.wire", capFrame, 48'h400000000095);
`endif

    for (int n = 0; n < 10; n++) begin
      k    = $urandom_range(0, 2);
      lead = $urandom_range(0, 9);
      len  = 3'($urandom_range(0, 7));
      cardQ.delete();
      for (int i = 0; i < lead; i++) cardQ.push_back(8'($urandom_range(0, 255)) | 8'h80);
      cardQ.push_back(8'($urandom_range(0, 255)) & 8'h7F);
      for (int i = 0; i < 6; i++) cardQ.push_back(8'($urandom_range(0, 255)));
      runTxn(k, {16'($urandom), 32'($urandom)}, len, 1'($urandom_range(0, 1)), "rand");
    end

    cardQ.delete();
    cur = 1; sckRises = 0; rvAll = 0;
    @(posedge clk); #1;
    cmdIn = 48'h48000001AA87; lenIn = 3'd5; cmdValidW[1] = 1'b1;
    @(posedge clk); #1;
    cmdValidW[1] = 1'b0;
    waitCnt = 0;
    while (sckRises < 20 && waitCnt < 2000) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("abort.reached_bit20", sckRises, 20);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.cs_n", csW[1], 1);
    chk("abort.sck", sckW[1], 0);
    chk("abort.ready", cmdReadyW[1], 1);
    chk("abort.busy", busyW[1], 0);
    reset_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("abort.no_resp", rvAll, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
